fa_fault_bist_ctrl: RTL and testbench
=====================================

Name: fa_fault_bist_ctrl

Overview:
Sequential BIST controller for the full-adder fault detector. It drives the detector's a/b/cin/fault_select inputs through every input vector and every fault index. After a settle delay it samples the detector's fault_sum_detected / fault_carry_detected outputs and accumulates per-fault detection counts. It also produces a detected-fault bitmap, a golden-run error flag and a done pulse for the test supervisor.

Parameters:
NUM_FAULTS, 5, number of fault indices swept (0 = fault-free, 1..NUM_FAULTS-1 = injected faults); max 8
SETTLE, 1, cycles a stimulus is held before sampling (1..15)
CNT_W, 4, width of per-fault detection counters (must hold 8)

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  start sweep; sampled only in IDLE or DONE
abort  in  1  stop sweep, return to IDLE
a  out  1  adder operand A to detector
b  out  1  adder operand B to detector
cin  out  1  carry-in to detector
fault_select  out  3  fault index to detector
fs_in  in  1  fault_sum_detected from detector
fc_in  in  1  fault_carry_detected from detector
busy  out  1  sweep in progress
done  out  1  sweep complete, held until next start or reset
golden_error  out  1  detector flagged a fault while fault_select==0
fault_detected  out  NUM_FAULTS  bit k = fault k detected by at least one vector
rd_sel  in  3  fault index for count readback
rd_sum_cnt  out  CNT_W  sum-detect count for fault rd_sel (combinational read)
rd_carry_cnt  out  CNT_W  carry-detect count for fault rd_sel

Behaviour:
- Reset (async, rst_n=0): state IDLE; a=b=cin=0, fault_select=0; busy=0, done=0, golden_error=0; fault_detected=0; all counters 0. This applies immediately, including mid-sweep.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE: outputs held at 0. On start=1, go to APPLY with vec=0, flt=0. Clear all counters, fault_detected and golden_error. Set busy=1.
- Stimulus encoding: {a,b,cin}=vec[2:0], fault_select=flt. Both are registered and stable throughout APPLY and SAMPLE.
- APPLY: held for exactly SETTLE cycles (settle counter), then go to SAMPLE.
- SAMPLE (1 cycle): capture fs_in/fc_in.
  - fs_in=1: sum_cnt[flt]++.
  - fc_in=1: carry_cnt[flt]++.
  - Either set: fault_detected[flt]=1.
  - flt==0 and either set: golden_error=1.
  - Counters saturate at 2^CNT_W-1.
- Sweep order after SAMPLE: fault index is the inner loop, vector the outer loop.
  - flt<NUM_FAULTS-1: flt++, go to APPLY.
  - Otherwise flt=0 and vec++. If vec was 7, go to DONE.
- Timing: a full sweep takes 8*NUM_FAULTS*(SETTLE+1) cycles from the first APPLY cycle; with defaults that is 80. The last SAMPLE is followed by DONE on the next edge.
- DONE: busy=0, done=1. Stimulus returns to 0. Results hold. start=1 restarts as from IDLE: counters clear and done drops on the same edge.
- start while busy: ignored.
- abort=1 in APPLY/SAMPLE: go to IDLE next edge. busy=0, done stays 0, partial counters and flags retained. abort has priority over SAMPLE accumulation in the same cycle; that sample is discarded.
- abort in IDLE/DONE: no effect. Simultaneous start+abort in IDLE/DONE: abort wins, no start.
- rd_sel >= NUM_FAULTS: rd_sum_cnt=rd_carry_cnt=0.
- fs_in/fc_in are ignored outside SAMPLE.

Test Plan:
- Reset then start, detector stub fs=fc=0 always -> done asserts 80 cycles after first APPLY; busy low; all counts 0; fault_detected=5'b00000; golden_error=0.
- Stub fs=1 iff fault_select==1 and a==1 -> rd_sel=1 gives rd_sum_cnt=4, rd_carry_cnt=0; fault_detected=5'b00010.
- Stub fc=1 iff fault_select==3 (all vectors), fs=1 iff fault_select==0 and vec==5 -> carry_cnt[3]=8, sum_cnt[0]=1; golden_error=1; fault_detected=5'b01001.
- SETTLE=3, monitor the stimulus bus -> each (vec,flt) pair held exactly 4 cycles, order (0,0),(0,1)..(0,4),(1,0)..(7,4).
- abort asserted on the 20th cycle of a sweep with the stub from scenario 2 -> IDLE next edge, busy=0, done=0, partial counts retained. A subsequent start clears them, and the full sweep again yields sum_cnt[1]=4.
- rst_n pulsed low mid-APPLY -> a,b,cin,fault_select, busy and counters go to 0 without waiting for clk. start pressed again during busy has no effect on sequence order.

Source files
------------

// File: rtl/fa_fault_bist_ctrl.sv
// BIST sequencer for the full-adder fault detector: sweeps every input vector
// against every fault index, samples the detector flags and accumulates per-fault results.
module fa_fault_bist_ctrl #(
    parameter int NUM_FAULTS = 5,
    parameter int SETTLE     = 1,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  a,
    output logic                  b,
    output logic                  cin,
    output logic [2:0]            fault_select,
    input  logic                  fs_in,
    input  logic                  fc_in,
    output logic                  busy,
    output logic                  done,
    output logic                  golden_error,
    output logic [NUM_FAULTS-1:0] fault_detected,
    input  logic [2:0]            rd_sel,
    output logic [CNT_W-1:0]      rd_sum_cnt,
    output logic [CNT_W-1:0]      rd_carry_cnt,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [2:0] LAST_FLT    = 3'(NUM_FAULTS - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state, state_nxt;
    logic [2:0] vec, vec_nxt;
    logic [2:0] flt, flt_nxt;
    logic [3:0] settle_cnt, settle_nxt;
    logic       clear_res;
    logic       do_sample;

    logic [CNT_W-1:0] sum_cnt   [NUM_FAULTS];
    logic [CNT_W-1:0] carry_cnt [NUM_FAULTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            vec        <= 3'd0;
            flt        <= 3'd0;
            settle_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            vec        <= vec_nxt;
            flt        <= flt_nxt;
            settle_cnt <= settle_nxt;
        end
    end

    // Fault index is the inner loop, vector the outer loop; abort beats sampling.
    always_comb begin
        state_nxt  = state;
        vec_nxt    = vec;
        flt_nxt    = flt;
        settle_nxt = settle_cnt;
        clear_res  = 1'b0;
        do_sample  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start && !abort) begin
                    state_nxt  = S_APPLY;
                    vec_nxt    = 3'd0;
                    flt_nxt    = 3'd0;
                    settle_nxt = 4'd0;
                    clear_res  = 1'b1;
                end
            end
            S_APPLY: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = S_SAMPLE;
                end else begin
                    settle_nxt = settle_cnt + 4'd1;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    do_sample  = 1'b1;
                    settle_nxt = 4'd0;
                    if (flt < LAST_FLT) begin
                        flt_nxt   = flt + 3'd1;
                        state_nxt = S_APPLY;
                    end else begin
                        flt_nxt = 3'd0;
                        if (vec == 3'd7) begin
                            state_nxt = S_DONE;
                        end else begin
                            vec_nxt   = vec + 3'd1;
                            state_nxt = S_APPLY;
                        end
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stimulus is registered from the next-state view so it is stable for the whole pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {a, b, cin}  <= 3'd0;
            fault_select <= 3'd0;
        end else if (state_nxt == S_APPLY || state_nxt == S_SAMPLE) begin
            {a, b, cin}  <= vec_nxt;
            fault_select <= flt_nxt;
        end else begin
            {a, b, cin}  <= 3'd0;
            fault_select <= 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_FAULTS; k++) begin
                sum_cnt[k]   <= '0;
                carry_cnt[k] <= '0;
            end
            fault_detected <= '0;
            golden_error   <= 1'b0;
        end else if (clear_res) begin
            for (int k = 0; k < NUM_FAULTS; k++) begin
                sum_cnt[k]   <= '0;
                carry_cnt[k] <= '0;
            end
            fault_detected <= '0;
            golden_error   <= 1'b0;
        end else if (do_sample) begin
            for (int k = 0; k < NUM_FAULTS; k++) begin
                if (flt == 3'(k)) begin
                    if (fs_in && (sum_cnt[k] != '1)) begin
                        sum_cnt[k] <= sum_cnt[k] + 1'b1;
                    end
                    if (fc_in && (carry_cnt[k] != '1)) begin
                        carry_cnt[k] <= carry_cnt[k] + 1'b1;
                    end
                    if (fs_in || fc_in) begin
                        fault_detected[k] <= 1'b1;
                    end
                end
            end
            if ((flt == 3'd0) && (fs_in || fc_in)) begin
                golden_error <= 1'b1;
            end
        end
    end

    // Out-of-range rd_sel matches no index and reads back zero.
    always_comb begin
        rd_sum_cnt   = '0;
        rd_carry_cnt = '0;
        for (int k = 0; k < NUM_FAULTS; k++) begin
            if (rd_sel == 3'(k)) begin
                rd_sum_cnt   = sum_cnt[k];
                rd_carry_cnt = carry_cnt[k];
            end
        end
    end

    assign busy      = (state == S_APPLY) || (state == S_SAMPLE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_fa_fault_bist_ctrl.sv
// Directed bench for fa_fault_bist_ctrl: a default instance driven by a detector stub
// and a SETTLE=3 instance used to check stimulus hold time and sweep order.
module tb_fa_fault_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0;
    logic       a, b, cin;
    logic [2:0] fault_select;
    logic       fs_in, fc_in;
    logic       busy, done, golden_error;
    logic [4:0] fault_detected;
    logic [2:0] rd_sel = 3'd0;
    logic [3:0] rd_sum_cnt, rd_carry_cnt;
    logic [1:0] state_dbg;

    logic       start_s3 = 1'b0;
    logic       a_s3, b_s3, cin_s3;
    logic [2:0] fault_select_s3;
    logic       busy_s3, done_s3, golden_error_s3;
    logic [4:0] fault_detected_s3;
    logic [3:0] rd_sum_cnt_s3, rd_carry_cnt_s3;
    logic [1:0] state_dbg_s3;

    int stub_mode = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fa_fault_bist_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .a(a), .b(b), .cin(cin), .fault_select(fault_select),
        .fs_in(fs_in), .fc_in(fc_in),
        .busy(busy), .done(done), .golden_error(golden_error),
        .fault_detected(fault_detected), .rd_sel(rd_sel),
        .rd_sum_cnt(rd_sum_cnt), .rd_carry_cnt(rd_carry_cnt), .state_dbg(state_dbg)
    );

    fa_fault_bist_ctrl #(.NUM_FAULTS(5), .SETTLE(3), .CNT_W(4)) u_dut_s3 (
        .clk(clk), .rst_n(rst_n), .start(start_s3), .abort(1'b0),
        .a(a_s3), .b(b_s3), .cin(cin_s3), .fault_select(fault_select_s3),
        .fs_in(1'b0), .fc_in(1'b0),
        .busy(busy_s3), .done(done_s3), .golden_error(golden_error_s3),
        .fault_detected(fault_detected_s3), .rd_sel(3'd0),
        .rd_sum_cnt(rd_sum_cnt_s3), .rd_carry_cnt(rd_carry_cnt_s3), .state_dbg(state_dbg_s3)
    );

    // Detector stub: 1 = sum fault on index 1 when a=1; 2 = carry fault on index 3,
    // plus a sum flag on the fault-free index for vector 5.
    always_comb begin
        fs_in = 1'b0;
        fc_in = 1'b0;
        case (stub_mode)
            1: fs_in = (fault_select == 3'd1) && a;
            2: begin
                fc_in = (fault_select == 3'd3);
                fs_in = (fault_select == 3'd0) && ({a, b, cin} == 3'd5);
            end
            default: ;
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // Starts a sweep and runs it to done, checking the stimulus of every cycle
    // against pair index (cycle/2); optionally pulses start at cycle restart_at.
    task automatic run_sweep(input int restart_at, output int cycles, output int order_errs);
        int idx;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        cycles = 0;
        order_errs = 0;
        while (cycles < 200) begin
            idx = cycles / 2;
            if ({a, b, cin} !== 3'(idx / 5) || fault_select !== 3'(idx % 5) || busy !== 1'b1)
                order_errs++;
            start = (cycles + 1 == restart_at);
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (done === 1'b1) break;
        end
        start = 1'b0;
    endtask

    task automatic abort_at(input int n);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (n - 1) begin
            @(posedge clk);
            @(negedge clk);
        end
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk) abort = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({a, b, cin, fault_select} !== 6'd0) begin
            failures++;
            $display("FAIL reset_stim: got %b expected 000000", {a, b, cin, fault_select});
        end
        checks++;
        if ({busy, done, golden_error} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got busy/done/gold=%b expected 000", {busy, done, golden_error});
        end
        checks++;
        if (fault_detected !== 5'd0 || state_dbg !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: got fd=%b st=%0d expected fd=00000 st=0", fault_detected, state_dbg);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_clean_sweep();
        int cyc, errs;
        stub_mode = 0;
        run_sweep(0, cyc, errs);
        checks++;
        if (cyc !== 80) begin
            failures++;
            $display("FAIL clean_latency: got %0d cycles expected 80", cyc);
        end
        checks++;
        if (errs !== 0) begin
            failures++;
            $display("FAIL clean_order: got %0d bad cycles expected 0", errs);
        end
        checks++;
        if ({busy, done, golden_error} !== 3'b010 || fault_detected !== 5'd0) begin
            failures++;
            $display("FAIL clean_flags: got b/d/g=%b fd=%b expected 010 00000", {busy, done, golden_error}, fault_detected);
        end
        checks++;
        if ({a, b, cin, fault_select} !== 6'd0) begin
            failures++;
            $display("FAIL clean_done_stim: got %b expected 000000", {a, b, cin, fault_select});
        end
        for (int k = 0; k < 5; k++) begin
            rd_sel = 3'(k);
            #1;
            checks++;
            if (rd_sum_cnt !== 4'd0 || rd_carry_cnt !== 4'd0) begin
                failures++;
                $display("FAIL clean_cnt%0d: got sum=%0d carry=%0d expected 0 0", k, rd_sum_cnt, rd_carry_cnt);
            end
        end
    endtask

    task automatic test_sum_fault1();
        int cyc, errs;
        stub_mode = 1;
        run_sweep(0, cyc, errs);
        rd_sel = 3'd1;
        #1;
        checks++;
        if (rd_sum_cnt !== 4'd4 || rd_carry_cnt !== 4'd0) begin
            failures++;
            $display("FAIL sum1_cnt: got sum=%0d carry=%0d expected 4 0", rd_sum_cnt, rd_carry_cnt);
        end
        checks++;
        if (fault_detected !== 5'b00010 || golden_error !== 1'b0) begin
            failures++;
            $display("FAIL sum1_flags: got fd=%b gold=%b expected 00010 0", fault_detected, golden_error);
        end
        rd_sel = 3'd0;
        #1;
        checks++;
        if (rd_sum_cnt !== 4'd0) begin
            failures++;
            $display("FAIL sum1_cnt0: got %0d expected 0", rd_sum_cnt);
        end
    endtask

    task automatic test_carry_golden();
        int cyc, errs;
        stub_mode = 2;
        run_sweep(0, cyc, errs);
        rd_sel = 3'd3;
        #1;
        checks++;
        if (rd_carry_cnt !== 4'd8 || rd_sum_cnt !== 4'd0) begin
            failures++;
            $display("FAIL carry3_cnt: got carry=%0d sum=%0d expected 8 0", rd_carry_cnt, rd_sum_cnt);
        end
        rd_sel = 3'd0;
        #1;
        checks++;
        if (rd_sum_cnt !== 4'd1 || rd_carry_cnt !== 4'd0) begin
            failures++;
            $display("FAIL golden_cnt: got sum=%0d carry=%0d expected 1 0", rd_sum_cnt, rd_carry_cnt);
        end
        checks++;
        if (fault_detected !== 5'b01001 || golden_error !== 1'b1) begin
            failures++;
            $display("FAIL carry_flags: got fd=%b gold=%b expected 01001 1", fault_detected, golden_error);
        end
        rd_sel = 3'd5;
        #1;
        checks++;
        if (rd_sum_cnt !== 4'd0 || rd_carry_cnt !== 4'd0) begin
            failures++;
            $display("FAIL rd_sel5: got sum=%0d carry=%0d expected 0 0", rd_sum_cnt, rd_carry_cnt);
        end
        rd_sel = 3'd7;
        #1;
        checks++;
        if (rd_sum_cnt !== 4'd0 || rd_carry_cnt !== 4'd0) begin
            failures++;
            $display("FAIL rd_sel7: got sum=%0d carry=%0d expected 0 0", rd_sum_cnt, rd_carry_cnt);
        end
    endtask

    task automatic test_done_start_abort();
        @(negedge clk) begin
            start = 1'b1;
            abort = 1'b1;
        end
        @(posedge clk);
        @(negedge clk) begin
            start = 1'b0;
            abort = 1'b0;
        end
        rd_sel = 3'd3;
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || rd_carry_cnt !== 4'd8) begin
            failures++;
            $display("FAIL start_abort_done: got done=%b busy=%b carry3=%0d expected 1 0 8", done, busy, rd_carry_cnt);
        end
    endtask

    task automatic test_settle3();
        int errs, idx;
        errs = 0;
        @(negedge clk) start_s3 = 1'b1;
        @(posedge clk);
        @(negedge clk) start_s3 = 1'b0;
        for (int i = 0; i < 160; i++) begin
            idx = i / 4;
            if ({a_s3, b_s3, cin_s3} !== 3'(idx / 5) || fault_select_s3 !== 3'(idx % 5) || busy_s3 !== 1'b1)
                errs++;
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (errs !== 0) begin
            failures++;
            $display("FAIL settle3_order: got %0d bad cycles expected 0", errs);
        end
        checks++;
        if (done_s3 !== 1'b1 || busy_s3 !== 1'b0) begin
            failures++;
            $display("FAIL settle3_done: got done=%b busy=%b expected 1 0", done_s3, busy_s3);
        end
    endtask

    task automatic test_abort();
        int cyc, errs;
        // Abort lands on the SAMPLE of (vec1, flt3): only (vec0, flt3) may count.
        stub_mode = 2;
        abort_at(18);
        rd_sel = 3'd3;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || state_dbg !== 2'd0) begin
            failures++;
            $display("FAIL abort_state: got busy=%b done=%b st=%0d expected 0 0 0", busy, done, state_dbg);
        end
        checks++;
        if (rd_carry_cnt !== 4'd1 || fault_detected !== 5'b01000 || golden_error !== 1'b0) begin
            failures++;
            $display("FAIL abort_partial: got carry3=%0d fd=%b gold=%b expected 1 01000 0", rd_carry_cnt, fault_detected, golden_error);
        end
        checks++;
        if ({a, b, cin, fault_select} !== 6'd0) begin
            failures++;
            $display("FAIL abort_stim: got %b expected 000000", {a, b, cin, fault_select});
        end
        stub_mode = 1;
        abort_at(20);
        rd_sel = 3'd1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_sum_cnt !== 4'd0) begin
            failures++;
            $display("FAIL abort20: got busy=%b done=%b sum1=%0d expected 0 0 0", busy, done, rd_sum_cnt);
        end
        rd_sel = 3'd3;
        #1;
        checks++;
        if (rd_carry_cnt !== 4'd0 || fault_detected !== 5'd0) begin
            failures++;
            $display("FAIL abort_restart_clear: got carry3=%0d fd=%b expected 0 00000", rd_carry_cnt, fault_detected);
        end
        run_sweep(0, cyc, errs);
        rd_sel = 3'd1;
        #1;
        checks++;
        if (rd_sum_cnt !== 4'd4 || cyc !== 80) begin
            failures++;
            $display("FAIL abort_rerun: got sum1=%0d cycles=%0d expected 4 80", rd_sum_cnt, cyc);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        stub_mode = 2;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        rd_sel = 3'd1;
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || rd_sum_cnt !== 4'd0) begin
            failures++;
            $display("FAIL restart_from_done: got done=%b busy=%b sum1=%0d expected 0 1 0", done, busy, rd_sum_cnt);
        end
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        rd_sel = 3'd3;
        #1;
        checks++;
        if (n !== 80 || rd_carry_cnt !== 4'd8) begin
            failures++;
            $display("FAIL back_to_back: got cycles=%0d carry3=%0d expected 80 8", n, rd_carry_cnt);
        end
    endtask

    task automatic test_reset_mid();
        stub_mode = 1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (46) begin
            @(posedge clk);
            @(negedge clk);
        end
        rd_sel = 3'd1;
        #1;
        checks++;
        if (rd_sum_cnt !== 4'd1 || fault_select !== 3'd3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: got sum1=%0d fsel=%0d busy=%b expected 1 3 1", rd_sum_cnt, fault_select, busy);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({a, b, cin, fault_select} !== 6'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_stim: got %b busy=%b expected 000000 0", {a, b, cin, fault_select}, busy);
        end
        checks++;
        if (rd_sum_cnt !== 4'd0 || fault_detected !== 5'd0 || state_dbg !== 2'd0) begin
            failures++;
            $display("FAIL async_reset_cnt: got sum1=%0d fd=%b st=%0d expected 0 00000 0", rd_sum_cnt, fault_detected, state_dbg);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_start_while_busy();
        int cyc, errs;
        stub_mode = 1;
        run_sweep(30, cyc, errs);
        rd_sel = 3'd1;
        #1;
        checks++;
        if (errs !== 0 || cyc !== 80) begin
            failures++;
            $display("FAIL start_busy_order: got bad=%0d cycles=%0d expected 0 80", errs, cyc);
        end
        checks++;
        if (rd_sum_cnt !== 4'd4 || fault_detected !== 5'b00010) begin
            failures++;
            $display("FAIL start_busy_result: got sum1=%0d fd=%b expected 4 00010", rd_sum_cnt, fault_detected);
        end
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_sum_fault1();
        test_carry_golden();
        test_done_start_abort();
        test_settle3();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_start_while_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
